usb_capture_arbiter: RTL and testbench

- Shares the single capture-buffer write port between the host-side and device-side packet monitor streams.
- Grants the port one whole packet at a time, with round-robin between sources, so host and device bytes never interleave inside a packet.
- Stamps each byte with the SOP-latched timestamp and source/boundary flags.
- Aborts stalled packets and keeps saturating packet and abort statistics for the control register block.

---
 rtl/usb_capture_arbiter_if.sv | 40 ++++
 rtl/usb_capture_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_usb_capture_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_capture_arbiter_if.sv
// usb_capture_arbiter_if
//   Bundles the two packet-monitor input streams (host and device) and the
//   capture-buffer write port shared between them.
//   slave  : arbiter side (consumes host/dev streams, drives the buffer port)
//   master : environment side (drives host/dev streams, accepts buffer bytes)
interface usb_capture_arbiter_if;
  logic [7:0]  host_data;
  logic        host_valid;
  logic        host_sop;
  logic        host_eop;
  logic        host_ready;
  logic [7:0]  dev_data;
  logic        dev_valid;
  logic        dev_sop;
  logic        dev_eop;
  logic        dev_ready;
  logic [7:0]  buffer_data;
  logic        buffer_valid;
  logic [63:0] buffer_timestamp;
  logic [7:0]  buffer_flags;
  logic        buffer_ready;

  modport slave (
    input  host_data, host_valid, host_sop, host_eop,
    output host_ready,
    input  dev_data, dev_valid, dev_sop, dev_eop,
    output dev_ready,
    output buffer_data, buffer_valid, buffer_timestamp, buffer_flags,
    input  buffer_ready
  );

  modport master (
    output host_data, host_valid, host_sop, host_eop,
    input  host_ready,
    output dev_data, dev_valid, dev_sop, dev_eop,
    input  dev_ready,
    input  buffer_data, buffer_valid, buffer_timestamp, buffer_flags,
    output buffer_ready
  );
endinterface

// File: rtl/usb_capture_arbiter.sv
// usb_capture_arbiter
//   Shares the capture-buffer write port between the host and device monitor
//   streams, one whole packet per grant, round-robin on contention. Each byte
//   is stamped with the timestamp latched at its packet's first byte and with
//   source/sop/eop/abort flags. A granted source that goes quiet for
//   IDLE_TIMEOUT cycles mid-packet gets an abort marker byte instead of a tail.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            when low no new grant is issued (open packet finishes)
//   timestamp         free-running time, sampled at the first byte of a grant
//   bus (slave)       host/dev streams in, buffer write port out
//   host_pkt_count    completed host packets (saturating)
//   dev_pkt_count     completed device packets (saturating)
//   abort_count       aborted packets (saturating)
//   busy              a packet (or abort marker) is in progress
module usb_capture_arbiter #(
  parameter int IDLE_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [63:0]           timestamp,
  usb_capture_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]      host_pkt_count,
  output logic [CNT_W-1:0]      dev_pkt_count,
  output logic [7:0]            abort_count,
  output logic                  busy
);
  localparam int STALL_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOST  = 2'd1,
    ST_DEV   = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc_8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  state_t             state_q, state_d;
  logic               rr_q, rr_d;          // 0: host wins the next tie, 1: device
  logic               run_q;               // low only while in reset, gates ready
  logic               first_q, first_d;    // next accepted byte opens the grant
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [7:0]         data_q, data_d;
  logic [7:0]         flags_q, flags_d;
  logic               valid_q, valid_d;
  logic [63:0]        ts_q, ts_d;
  logic [CNT_W-1:0]   host_cnt_q, host_cnt_d;
  logic [CNT_W-1:0]   dev_cnt_q, dev_cnt_d;
  logic [7:0]         abort_cnt_q, abort_cnt_d;

  logic               gr_src_s;
  logic               gr_valid_s;
  logic               gr_eop_s;
  logic [7:0]         gr_data_s;
  logic               slot_free_s;
  logic               host_req_s;
  logic               dev_req_s;
  logic               host_ready_s;
  logic               dev_ready_s;

  assign slot_free_s = !valid_q || bus.buffer_ready;
  assign host_req_s  = enable && bus.host_valid && bus.host_sop;
  assign dev_req_s   = enable && bus.dev_valid && bus.dev_sop;

  // Select the stream that currently owns the port.
  always_comb begin
    if (state_q == ST_DEV) begin
      gr_src_s   = 1'b1;
      gr_valid_s = bus.dev_valid;
      gr_eop_s   = bus.dev_eop;
      gr_data_s  = bus.dev_data;
    end else begin
      gr_src_s   = 1'b0;
      gr_valid_s = bus.host_valid;
      gr_eop_s   = bus.host_eop;
      gr_data_s  = bus.host_data;
    end
  end

  // Arbitration, byte transfer, stall detection and statistics.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    first_d      = first_q;
    stall_d      = stall_q;
    data_d       = data_q;
    flags_d      = flags_q;
    ts_d         = ts_q;
    host_cnt_d   = host_cnt_q;
    dev_cnt_d    = dev_cnt_q;
    abort_cnt_d  = abort_cnt_q;
    host_ready_s = 1'b0;
    dev_ready_s  = 1'b0;
    // The output register empties once the buffer takes its byte.
    if (valid_q && bus.buffer_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        // Stray non-sop bytes are swallowed; sop bytes wait for their grant.
        host_ready_s = run_q && bus.host_valid && !bus.host_sop;
        dev_ready_s  = run_q && bus.dev_valid && !bus.dev_sop;
        first_d      = 1'b1;
        stall_d      = '0;
        if (host_req_s && dev_req_s) begin
          state_d = rr_q ? ST_DEV : ST_HOST;
          rr_d    = !rr_q;
        end else if (host_req_s) begin
          state_d = ST_HOST;
        end else if (dev_req_s) begin
          state_d = ST_DEV;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HOST, ST_DEV: begin
        if (gr_src_s) begin
          dev_ready_s = slot_free_s;
        end else begin
          host_ready_s = slot_free_s;
        end
        if (gr_valid_s && slot_free_s) begin
          data_d  = gr_data_s;
          valid_d = 1'b1;
          // A mid-packet sop is plain data: only the grant's first byte gets bit1.
          flags_d = {4'b0000, 1'b0, gr_eop_s, first_q, gr_src_s};
          first_d = 1'b0;
          stall_d = '0;
          if (first_q) begin
            ts_d = timestamp;
          end else begin
            ts_d = ts_q;
          end
          if (gr_eop_s) begin
            state_d = ST_IDLE;
            if (gr_src_s) begin
              dev_cnt_d = sat_inc_cnt(dev_cnt_q);
            end else begin
              host_cnt_d = sat_inc_cnt(host_cnt_q);
            end
          end else begin
            state_d = state_q;
          end
        end else if (!gr_valid_s && slot_free_s) begin
          // Only source silence counts; buffer back-pressure freezes the timer.
          if (stall_q == STALL_MAX) begin
            state_d = ST_ABORT;
            data_d  = 8'h00;
            valid_d = 1'b1;
            flags_d = {4'b0000, 1'b1, 1'b1, 1'b0, gr_src_s};
            stall_d = '0;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end else begin
          stall_d = stall_q;
        end
      end

      ST_ABORT: begin
        if (bus.buffer_ready) begin
          valid_d     = 1'b0;
          state_d     = ST_IDLE;
          abort_cnt_d = sat_inc_8(abort_cnt_q);
        end else begin
          state_d = ST_ABORT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b0;
      run_q       <= 1'b0;
      first_q     <= 1'b1;
      stall_q     <= '0;
      data_q      <= 8'h00;
      flags_q     <= 8'h00;
      valid_q     <= 1'b0;
      ts_q        <= 64'h0;
      host_cnt_q  <= '0;
      dev_cnt_q   <= '0;
      abort_cnt_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      run_q       <= 1'b1;
      first_q     <= first_d;
      stall_q     <= stall_d;
      data_q      <= data_d;
      flags_q     <= flags_d;
      valid_q     <= valid_d;
      ts_q        <= ts_d;
      host_cnt_q  <= host_cnt_d;
      dev_cnt_q   <= dev_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign bus.host_ready       = host_ready_s;
  assign bus.dev_ready        = dev_ready_s;
  assign bus.buffer_data      = data_q;
  assign bus.buffer_valid     = valid_q;
  assign bus.buffer_flags     = flags_q;
  assign bus.buffer_timestamp = ts_q;
  assign host_pkt_count       = host_cnt_q;
  assign dev_pkt_count        = dev_cnt_q;
  assign abort_count          = abort_cnt_q;
  assign busy                 = (state_q != ST_IDLE);
endmodule

// File: tb/tb_usb_capture_arbiter.sv
module tb_usb_capture_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] timestamp = 64'h0;
  bit          ts_run = 1'b1;
  logic [15:0] host_cnt, dev_cnt;
  logic [7:0]  abort_cnt;
  logic        busy;
  logic [1:0]  s_host_cnt, s_dev_cnt;
  logic [7:0]  s_abort_cnt;
  logic        s_busy;

  usb_capture_arbiter_if bus_if();
  usb_capture_arbiter_if s_if();

  usb_capture_arbiter #(.IDLE_TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .timestamp(timestamp), .bus(bus_if),
    .host_pkt_count(host_cnt), .dev_pkt_count(dev_cnt), .abort_count(abort_cnt), .busy(busy));

  // Narrow-counter instance so saturation is reachable in a few cycles.
  usb_capture_arbiter #(.IDLE_TIMEOUT(4), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .enable(1'b1), .timestamp(64'h0), .bus(s_if),
    .host_pkt_count(s_host_cnt), .dev_pkt_count(s_dev_cnt), .abort_count(s_abort_cnt), .busy(s_busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [7:0]  flags;
    logic [63:0] ts;
  } rec_t;

  rec_t        exp_q[$];
  int          grant_log[$];
  int          owner = -1;
  logic [63:0] pkt_ts = 64'h0;
  logic [15:0] host_m = 16'h0, dev_m = 16'h0;
  logic [7:0]  abort_m = 8'h0;
  int          n_tests = 0, n_fail = 0;

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    owner   = -1;
    host_m  = 16'h0;
    dev_m   = 16'h0;
    abort_m = 8'h0;
  endtask

  // Record one accepted byte: packets must not interleave, first byte opens the packet.
  task automatic model_accept(input int src, input logic [7:0] d, input bit eop);
    bit first;
    n_tests++;
    if (owner != -1 && owner != src) begin
      n_fail++;
      $display("FAIL interleave: got byte from source %0d, expected source %0d", src, owner);
    end
    first = (owner != src);
    if (first) begin
      owner  = src;
      pkt_ts = timestamp;
      grant_log.push_back(src);
    end
    exp_q.push_back('{data: d, flags: {4'b0000, 1'b0, eop, first, src[0]}, ts: pkt_ts});
    if (eop) begin
      owner = -1;
      if (src == 0) host_m = sat16(host_m);
      else          dev_m  = sat16(dev_m);
    end
  endtask

  task automatic model_abort(input int src);
    exp_q.push_back('{data: 8'h00, flags: {4'b0000, 1'b1, 1'b1, 1'b0, src[0]}, ts: pkt_ts});
    owner = -1;
  endtask

  task automatic send_byte(input int src, input logic [7:0] d, input bit sop, input bit eop);
    bit ok = 1'b0;
    if (src == 0) begin
      bus_if.host_data = d; bus_if.host_sop = sop; bus_if.host_eop = eop; bus_if.host_valid = 1'b1;
    end else begin
      bus_if.dev_data = d; bus_if.dev_sop = sop; bus_if.dev_eop = eop; bus_if.dev_valid = 1'b1;
    end
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if ((src == 0) ? bus_if.host_ready : bus_if.dev_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (ok) begin
      model_accept(src, d, eop);
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: source %0d byte %h got no ready, expected ready", src, d);
    end
    if (src == 0) bus_if.host_valid = 1'b0;
    else          bus_if.dev_valid  = 1'b0;
  endtask

  task automatic send_pkt(input int src, input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++)
      send_byte(src, base + 8'(i), (i == 0), (i == len - 1));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus_if.buffer_valid) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Free-running time, advanced away from the sampling edge.
  initial forever begin
    @(negedge clk);
    if (ts_run) timestamp = timestamp + 64'd1;
  end

  // Compare process: byte stream order/content, hold stability, counters.
  initial begin
    rec_t        r;
    bit          hold_v = 1'b0;
    logic [80:0] prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        check("host_pkt_count", 64'(host_cnt), 64'(host_m));
        check("dev_pkt_count", 64'(dev_cnt), 64'(dev_m));
        check("abort_count", 64'(abort_cnt), 64'(abort_m));
        if (hold_v)
          check("hold_stable", 64'({bus_if.buffer_valid, bus_if.buffer_data, bus_if.buffer_flags, bus_if.buffer_timestamp} != prev), 64'd0);
        if (bus_if.buffer_valid && bus_if.buffer_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", 64'(bus_if.buffer_data), 64'hFFFF);
          end else begin
            r = exp_q.pop_front();
            check("out_data", 64'(bus_if.buffer_data), 64'(r.data));
            check("out_flags", 64'(bus_if.buffer_flags), 64'(r.flags));
            check("out_timestamp", bus_if.buffer_timestamp, r.ts);
            if (r.flags[3]) abort_m = (abort_m == 8'hFF) ? abort_m : abort_m + 8'd1;
          end
        end
        hold_v = bus_if.buffer_valid && !bus_if.buffer_ready;
        prev   = {bus_if.buffer_valid, bus_if.buffer_data, bus_if.buffer_flags, bus_if.buffer_timestamp};
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.host_data = 8'h00; bus_if.host_valid = 1'b0; bus_if.host_sop = 1'b0; bus_if.host_eop = 1'b0;
    bus_if.dev_data = 8'h00;  bus_if.dev_valid = 1'b0;  bus_if.dev_sop = 1'b0;  bus_if.dev_eop = 1'b0;
    bus_if.buffer_ready = 1'b1;
    s_if.host_data = 8'h00; s_if.host_valid = 1'b0; s_if.host_sop = 1'b0; s_if.host_eop = 1'b0;
    s_if.dev_data = 8'h00;  s_if.dev_valid = 1'b0;  s_if.dev_sop = 1'b0;  s_if.dev_eop = 1'b0;
    s_if.buffer_ready = 1'b1;

    // Reset state
    #12;
    check("rst_buffer", 64'({bus_if.buffer_valid, bus_if.buffer_data, bus_if.buffer_flags}), 64'd0);
    check("rst_timestamp", bus_if.buffer_timestamp, 64'd0);
    check("rst_ready_busy", 64'({bus_if.host_ready, bus_if.dev_ready, busy}), 64'd0);
    check("rst_counts", 64'({host_cnt, dev_cnt, abort_cnt}), 64'd0);
    #11 rst_n = 1'b1;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Simultaneous sop twice: host wins first, device wins the rematch
    for (int r = 0; r < 2; r++) begin
      grant_log.delete();
      fork
        send_pkt(0, 8'h10, 3);
        send_pkt(1, 8'h20, 2);
      join
      drain();
      check("rr_first_grant", 64'(grant_log[0]), (r == 0) ? 64'd0 : 64'd1);
      check("rr_second_grant", 64'(grant_log[1]), (r == 0) ? 64'd1 : 64'd0);
    end

    // Host packet A5,01,02 at timestamp 0x100
    ts_run = 1'b0;
    timestamp = 64'h100;
    send_byte(0, 8'hA5, 1'b1, 1'b0);
    ts_run = 1'b1;
    check("a5_byte0", 64'({bus_if.buffer_data, bus_if.buffer_flags}), 64'hA502);
    check("a5_ts0", bus_if.buffer_timestamp, 64'h100);
    send_byte(0, 8'h01, 1'b0, 1'b0);
    check("a5_byte1", 64'({bus_if.buffer_data, bus_if.buffer_flags}), 64'h0100);
    check("a5_ts1", bus_if.buffer_timestamp, 64'h100);
    send_byte(0, 8'h02, 1'b0, 1'b1);
    check("a5_byte2", 64'({bus_if.buffer_data, bus_if.buffer_flags}), 64'h0204);
    check("a5_ts2", bus_if.buffer_timestamp, 64'h100);
    drain();
    check("a5_host_count", 64'(host_cnt), 64'd3);

    // Five-cycle buffer back-pressure mid-packet
    fork
      send_pkt(0, 8'h30, 6);
      begin
        repeat (3) @(posedge clk);
        #1 bus_if.buffer_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus_if.buffer_ready = 1'b1;
      end
    join
    drain();
    check("bp_no_abort", 64'(abort_cnt), 64'd0);

    // Long back-pressure while the source is silent, then a mid-packet sop
    send_byte(1, 8'h40, 1'b1, 1'b0);
    bus_if.buffer_ready = 1'b0;
    repeat (80) @(posedge clk);
    #1 bus_if.buffer_ready = 1'b1;
    send_byte(1, 8'h41, 1'b1, 1'b0);
    check("mid_sop_flags", 64'(bus_if.buffer_flags), 64'h01);
    send_byte(1, 8'h42, 1'b0, 1'b1);
    drain();
    check("bp_long_no_abort", 64'(abort_cnt), 64'd0);
    check("bp_dev_count", 64'(dev_cnt), 64'd3);

    // Device stalls after two bytes: marker after exactly 64 silent cycles
    send_byte(1, 8'h50, 1'b1, 1'b0);
    send_byte(1, 8'h51, 1'b0, 1'b0);
    model_abort(1);
    repeat (63) @(posedge clk);
    @(negedge clk);
    check("abort_not_early", 64'({bus_if.buffer_valid, busy}), 64'b01);
    @(posedge clk);
    @(negedge clk);
    check("abort_marker", 64'({bus_if.buffer_valid, bus_if.buffer_data, bus_if.buffer_flags}), 64'h1_00_0D);
    drain();
    check("abort_count_1", 64'(abort_cnt), 64'd1);
    check("abort_dev_count", 64'(dev_cnt), 64'd3);
    send_pkt(0, 8'h60, 2);
    drain();
    check("after_abort_host", 64'(host_cnt), 64'd5);

    // enable low blocks a grant but not an open packet; single-byte packet
    enable = 1'b0;
    fork
      send_byte(1, 8'h70, 1'b1, 1'b0);
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("enable_blocks", 64'({busy, bus_if.dev_ready}), 64'd0);
        enable = 1'b1;
      end
    join
    enable = 1'b0;
    send_byte(1, 8'h71, 1'b0, 1'b0);
    send_byte(1, 8'h72, 1'b0, 1'b1);
    drain();
    check("enable_low_completes", 64'({busy, dev_cnt}), 64'd4);
    enable = 1'b1;
    send_byte(1, 8'h73, 1'b1, 1'b1);
    check("single_byte_flags", 64'(bus_if.buffer_flags), 64'h07);
    drain();
    check("single_byte_count", 64'(dev_cnt), 64'd5);

    // Reset mid-packet with a byte held in the output register
    bus_if.buffer_ready = 1'b0;
    send_byte(0, 8'h80, 1'b1, 1'b0);
    bus_if.host_data = 8'h81; bus_if.host_sop = 1'b0; bus_if.host_eop = 1'b0; bus_if.host_valid = 1'b1;
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_buffer", 64'({bus_if.buffer_valid, bus_if.buffer_data, bus_if.buffer_flags}), 64'd0);
    check("midrst_timestamp", bus_if.buffer_timestamp, 64'd0);
    check("midrst_ready_busy", 64'({bus_if.host_ready, bus_if.dev_ready, busy}), 64'd0);
    check("midrst_counts", 64'({host_cnt, dev_cnt, abort_cnt}), 64'd0);
    #10 rst_n = 1'b1;
    bus_if.buffer_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_discard", 64'({bus_if.host_ready, bus_if.buffer_valid, busy}), 64'b100);
    #1 bus_if.host_valid = 1'b0;
    send_byte(0, 8'h90, 1'b1, 1'b0);
    check("post_rst_sop_flags", 64'({bus_if.buffer_data, bus_if.buffer_flags}), 64'h9002);
    send_byte(0, 8'h91, 1'b0, 1'b1);
    drain();
    check("post_rst_count", 64'(host_cnt), 64'd1);

    // Counter saturation on the narrow instance
    s_if.host_valid = 1'b1; s_if.host_sop = 1'b1; s_if.host_eop = 1'b1; s_if.host_data = 8'h5A;
    repeat (20) @(posedge clk);
    #1;
    check("sat_host_count", 64'(s_host_cnt), 64'd3);
    repeat (6) @(posedge clk);
    #1;
    check("sat_host_hold", 64'({s_host_cnt, s_dev_cnt, s_abort_cnt}), 64'({2'd3, 2'd0, 8'd0}));
    s_if.host_valid = 1'b0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
